seg_scan_decoder: RTL and testbench

- Monitors a multiplexed 4-digit common-anode 7-segment bus and recovers the hexadecimal value shown on each digit.
- It is the reverse of the segment encoders: it converts segment patterns back into 4-bit codes.
- Sits beside the display driver as a self-check and readback path. It qualifies each digit's dwell for stability, decodes it, and reports decode errors and frame completion.

---
 rtl/seg_scan_decoder.sv | 186 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed 4-digit common-anode 7-segment bus back into hex codes.
// Each digit dwell is qualified for stability, then decoded once per dwell.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic        seg_err,
  output logic [1:0]  err_digit,
  output logic        frame_done
);

  localparam int unsigned SNAP_W = 11;
  localparam logic [SNAP_W-1:0] SNAP_IDLE = {4'hF, 7'h7F};
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t              state, state_nxt;
  logic [SNAP_W-1:0]   snap, snap_prev;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          seen;

  logic [3:0]          an_s;
  logic [6:0]          seg_s;
  logic                changed_c;
  logic                active_c;
  logic                stable_c;
  logic                capture_c;
  logic [CNT_W-1:0]    cnt_eff_c;
  logic [1:0]          idx_c;
  logic                dec_ok_c;
  logic                blank_c;
  logic [3:0]          dec_code_c;
  logic [3:0]          seen_set_c;

  assign an_s  = snap[10:7];
  assign seg_s = snap[6:0];

  // Snapshot register, previous snapshot, and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      snap      <= SNAP_IDLE;
      snap_prev <= SNAP_IDLE;
      cnt       <= '0;
      state     <= IDLE;
    end else begin
      snap      <= {an_n, seg_n};
      snap_prev <= snap;
      cnt       <= cnt_eff_c;
      state     <= state_nxt;
    end
  end

  // Count as seen this cycle: restarts at 1 on change, saturates at STABLE_CYCLES
  always_comb begin
    changed_c = (snap != snap_prev);
    if (changed_c)
      cnt_eff_c = CNT_ONE;
    else if (cnt >= CNT_MAX)
      cnt_eff_c = CNT_MAX;
    else
      cnt_eff_c = cnt + CNT_ONE;
    stable_c = (cnt_eff_c == CNT_MAX);
    active_c = $onehot(~an_s);
  end

  always_comb begin
    idx_c = 2'd0;
    case (an_s)
      4'b1110: idx_c = 2'd0;
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase
  end

  always_comb begin
    dec_ok_c   = 1'b1;
    dec_code_c = 4'h0;
    blank_c    = (seg_s == 7'h7F);
    case (seg_s)
      7'h40: dec_code_c = 4'h0;
      7'h79: dec_code_c = 4'h1;
      7'h24: dec_code_c = 4'h2;
      7'h30: dec_code_c = 4'h3;
      7'h19: dec_code_c = 4'h4;
      7'h12: dec_code_c = 4'h5;
      7'h02: dec_code_c = 4'h6;
      7'h78: dec_code_c = 4'h7;
      7'h00: dec_code_c = 4'h8;
      7'h10: dec_code_c = 4'h9;
      7'h08: dec_code_c = 4'hA;
      7'h03: dec_code_c = 4'hB;
      7'h46: dec_code_c = 4'hC;
      7'h21: dec_code_c = 4'hD;
      7'h06: dec_code_c = 4'hE;
      7'h0E: dec_code_c = 4'hF;
      default: dec_ok_c = 1'b0;
    endcase
  end

  // Next state; IDLE and HOLD may capture directly so STABLE_CYCLES=1 works
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (active_c) begin
          if (stable_c) begin
            capture_c = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = TRACK;
          end
        end
      end
      TRACK: begin
        if (!active_c) begin
          state_nxt = IDLE;
        end else if (stable_c) begin
          capture_c = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!active_c) begin
          state_nxt = IDLE;
        end else if (changed_c) begin
          if (stable_c) begin
            capture_c = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = TRACK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign seen_set_c = seen | (4'b0001 << idx_c);

  // Capture results; error pulses never mark a digit as seen
  always_ff @(posedge clk) begin
    if (rst) begin
      digits     <= '0;
      dig_valid  <= '0;
      seg_err    <= 1'b0;
      err_digit  <= '0;
      frame_done <= 1'b0;
      seen       <= '0;
    end else begin
      seg_err    <= 1'b0;
      frame_done <= 1'b0;
      if (capture_c) begin
        if (dec_ok_c || blank_c) begin
          if (dec_ok_c) begin
            digits[{idx_c, 2'b00} +: 4] <= dec_code_c;
            dig_valid[idx_c]            <= 1'b1;
          end else begin
            dig_valid[idx_c] <= 1'b0;
          end
          if (seen_set_c == 4'hF) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen_set_c;
          end
        end else begin
          dig_valid[idx_c] <= 1'b0;
          seg_err          <= 1'b1;
          err_digit        <= idx_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected output events are queued as
// stimulus is issued and popped by a negedge monitor whenever outputs move.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic        seg_err;
  logic [1:0]  err_digit;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;
  logic        mon_en = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] prev = '0;

  seg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .digits(digits), .dig_valid(dig_valid), .seg_err(seg_err),
    .err_digit(err_digit), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ev(input logic [15:0] d, input logic [3:0] v,
                                     input logic e, input logic [1:0] ed, input logic f);
    return {d, v, e, ed, f};
  endfunction

  // Event = any change of digits/dig_valid, or a pulse on seg_err/frame_done
  always @(negedge clk) begin
    logic [23:0] cur;
    logic [23:0] exp;
    if (mon_en) begin
      cur = {digits, dig_valid, seg_err, err_digit, frame_done};
      if (seg_err || frame_done || (cur[23:4] != prev[23:4])) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event t=%0t got=%h (no event expected)", $time, cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            mismatched++;
            $display("FAIL event t=%0t got=%h want=%h", $time, cur, exp);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic direct(input string name, input logic [23:0] got, input logic [23:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    direct("reset_state", {digits, dig_valid, seg_err, err_digit, frame_done}, 24'h0);
    mon_en = 1'b1;

    // Full scan 0..3 -> 3210, one frame_done at digit 3
    exp_q.push_back(ev(16'h0000, 4'b0001, 1'b0, 2'd0, 1'b0));
    show(4'b1110, 7'h40, 8);
    exp_q.push_back(ev(16'h0010, 4'b0011, 1'b0, 2'd0, 1'b0));
    show(4'b1101, 7'h79, 8);
    exp_q.push_back(ev(16'h0210, 4'b0111, 1'b0, 2'd0, 1'b0));
    show(4'b1011, 7'h24, 8);
    exp_q.push_back(ev(16'h3210, 4'b1111, 1'b0, 2'd0, 1'b1));
    show(4'b0111, 7'h30, 8);

    // Short dwell (3 < 4) on digit 2: no capture
    show(4'b1011, 7'h19, 3);
    show(4'b1111, 7'h7F, 6);

    // Undecodable pattern on digit 1
    exp_q.push_back(ev(16'h3210, 4'b1101, 1'b1, 2'd1, 1'b0));
    show(4'b1101, 7'h55, 6);

    // Unstable toggling on digit 0, then hold F
    for (int i = 0; i < 10; i++)
      show(4'b1110, (i % 2 == 0) ? 7'h40 : 7'h79, 2);
    exp_q.push_back(ev(16'h321F, 4'b1101, 1'b0, 2'd1, 1'b0));
    show(4'b1110, 7'h0E, 8);

    // Two anodes low: ignored; then blank on digit 3
    show(4'b1100, 7'h24, 10);
    exp_q.push_back(ev(16'h321F, 4'b0101, 1'b0, 2'd1, 1'b0));
    show(4'b0111, 7'h7F, 8);

    // Frame completes only once digit 1 shows a good pattern
    exp_q.push_back(ev(16'h341F, 4'b0101, 1'b0, 2'd1, 1'b0));
    show(4'b1011, 7'h19, 8);
    exp_q.push_back(ev(16'h341F, 4'b0111, 1'b0, 2'd1, 1'b1));
    show(4'b1101, 7'h79, 8);

    // Reset mid-dwell after 3 stable samples, dwell restarts afterwards
    show(4'b1111, 7'h7F, 4);
    exp_q.push_back(ev(16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0));
    exp_q.push_back(ev(16'h0002, 4'b0001, 1'b0, 2'd0, 1'b0));
    show(4'b1110, 7'h24, 3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    direct("no_capture_before_latency", {20'h0, dig_valid}, 24'h0);
    @(posedge clk);
    @(negedge clk);
    direct("capture_after_reset", {digits, dig_valid, 4'h0}, {16'h0002, 4'b0001, 4'h0});

    show(4'b1110, 7'h24, 6);
    show(4'b1111, 7'h7F, 4);
    @(negedge clk);
    direct("queue_drained", 24'(exp_q.size()), 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
